// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; otherwise reads have 1-cycle latency.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       write_enable,
  input  logic                       read_enable,
  input  logic                       clear_err,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
`ifndef SYNC_FIFO_FWFT_EN
  logic              data_valid_q, data_valid_d;
`endif

  logic [AW-1:0] waddr, raddr;
  logic          empty_c, full_c, wr_ok, rd_ok;

  // Handshake: a read is accepted whenever the FIFO holds data; a write is accepted
  // when there is space or when a same-cycle accepted read frees a slot. Rejected
  // requests leave pointers, count, memory and data_out untouched and set a sticky error.
  always_comb begin
    waddr   = wptr_q[AW-1:0];
    raddr   = rptr_q[AW-1:0];
    empty_c = (wptr_q == rptr_q);
    full_c  = (waddr == raddr) && (wptr_q[AW] != rptr_q[AW]);
    rd_ok   = read_enable & ~empty_c;
    wr_ok   = write_enable & (~full_c | rd_ok);

    wptr_d = wr_ok ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d = rd_ok ? (rptr_q + PTR_ONE) : rptr_q;

    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase

    // In both read modes data_out_q captures the popped word, so it also serves
    // as the "last popped value" shown by fall-through mode when empty.
    data_out_d = rd_ok ? mem_q[raddr] : data_out_q;

    // A new error in the same cycle as clear_err keeps the flag set.
    overflow_d  = (clear_err ? 1'b0 : overflow_q)  | (write_enable & ~wr_ok);
    underflow_d = (clear_err ? 1'b0 : underflow_q) | (read_enable & ~rd_ok);
`ifndef SYNC_FIFO_FWFT_EN
    data_valid_d = rd_ok;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      data_valid_q <= 1'b0;
`endif
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
`ifndef SYNC_FIFO_FWFT_EN
      data_valid_q <= data_valid_d;
`endif
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[waddr] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out   = empty_c ? data_out_q : mem_q[raddr];
  assign data_valid = ~empty_c;
`else
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

  assign full         = full_c;
  assign empty        = empty_c;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8x8 FIFO.
- Adds configurable width and depth, and true simultaneous read/write.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Buffers data between a stimulus/producer block and a consumer in the same clock domain.

Parameters:
- DATA_W, 8: data word width in bits, >=1.
- DEPTH, 8: number of entries; must be a power of two, >=2.
- AF_THRESH, 6: almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high; clears all state.
- data_in  in  DATA_W  write data.
- write_enable  in  1  write request.
- read_enable  in  1  read request.
- clear_err  in  1  synchronous clear of overflow/underflow.
- data_out  out  DATA_W  read data.
- data_valid  out  1  data_out holds a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (asynchronous assert):
  - Write/read pointers, count, data_out, data_valid, overflow and underflow go to 0.
  - Outputs become: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0), i.e. 0 for legal settings.
  - Storage array is not cleared.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Pointers: $clog2(DEPTH)+1 bits wide (one extra wrap bit).
  - Address = low bits.
  - full when addresses are equal and wrap bits differ; empty when pointers are identical.
  - Pointers wrap modulo 2*DEPTH with no special case at DEPTH-1 -> 0.
- Write accept: wr_ok = write_enable & (!full | rd_ok).
  - On wr_ok: mem[wptr] <= data_in and wptr+1.
- Read accept: rd_ok = read_enable & !empty.
  - On rd_ok: data_out <= mem[rptr] and rptr+1, so read latency is 1 cycle.
  - data_valid = 1 in the cycle after rd_ok, otherwise 0.
  - data_out holds its value when there is no read.
- Simultaneous read and write:
  - Not full, not empty: both accepted; count unchanged.
  - Full: both accepted; the read frees the slot; count stays DEPTH; no overflow.
  - Empty: write accepted, read rejected; underflow set; count becomes 1. No bypass of write data to data_out.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged if both or neither. Registered.
- Flags full, empty, almost_full, almost_empty are combinational decodes of the registered pointers/count, so they update the cycle after the causing edge.
- Errors:
  - overflow <= 1 when write_enable & !wr_ok.
  - underflow <= 1 when read_enable & !rd_ok.
  - Both flags stay set until clear_err or rst.
  - If clear_err and a new error occur in the same cycle, the error wins (the flag stays 1).
- Rejected accesses change no pointer, no count, no memory and no data_out.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out continuously shows mem[rptr] while !empty, with zero read latency.
  - data_valid = !empty.
  - read_enable acknowledges (pops) the displayed word.
  - When empty, data_out shows the last popped value; 0 after reset.
  - Write into an empty FIFO: word visible on data_out the cycle after the write edge.
- Not defined: standard 1-cycle registered read as described in Behaviour.

Test Plan:
- Reset and idle: assert rst asynchronously between clock edges -> count=0, empty=1, full=0, almost_empty=1, data_out=0, flags=0 without a clock edge.
- Fill and drain, DEPTH=8, DATA_W=8:
  - Write 0x10..0x17 -> full=1 and count=8 after 8th edge; almost_full rises when count reaches 6.
  - Read 8 times -> data_out 0x10..0x17 in order, each 1 cycle after read; empty=1 at end.
- Wrap-around: write 5, read 5, write 8, read 8 -> second burst read back exactly in order; full asserted only at count=8.
- Simultaneous R/W at full: fill with 0xA0..0xA7, then write 0xB0 with read -> data_out=0xA0, count stays 8, overflow=0; subsequent reads end with 0xB0.
- Errors:
  - Write when full without read -> overflow=1, contents unchanged.
  - Read when empty -> underflow=1.
  - Pulse clear_err -> both 0.
  - clear_err in the same cycle as a new overflow -> overflow stays 1.
- FWFT build: write 0x3C into empty FIFO -> next cycle data_valid=1, data_out=0x3C with no read; read_enable pops it -> empty=1, data_valid=0.
